// File: rtl/wallace_final_cpa_if.sv
// Handshake/data bundle for the Wallace multiplier final carry-propagate stage.
// Upstream side: in_valid/in_ready with the last carry-save pair, resolved low
// product bits and the reservation-station tag.
// Downstream side: out_valid/out_ready with the 64-bit product and its tag.
//   slave  : the carry-propagate stage itself
//   master : the producer/consumer environment driving it
interface wallace_final_cpa_if #(
    parameter int LSB_W = 6,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [57:0]      sum_vec;
    logic [58:0]      carry_vec;
    logic [LSB_W-1:0] lsb_bits;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      product;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, sum_vec, carry_vec, lsb_bits, in_tag, out_ready,
        output in_ready, out_valid, product, out_tag
    );

    modport master (
        output in_valid, sum_vec, carry_vec, lsb_bits, in_tag, out_ready,
        input  in_ready, out_valid, product, out_tag
    );
endinterface

// File: rtl/wallace_final_cpa.sv
// Final carry-propagate adder of the 32x32 Wallace multiplier.
// Adds the last carry-save pair one SEG_W-bit slice per cycle with a rippled
// carry, appends the already-resolved low product bits and returns the tagged
// 64-bit product.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   cpa  - wallace_final_cpa_if.slave: in_valid/in_ready, sum_vec, carry_vec,
//          lsb_bits, in_tag, out_valid/out_ready, product, out_tag
module wallace_final_cpa #(
    parameter int LSB_W = 6,
    parameter int SEG_W = 16,
    parameter int TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    wallace_final_cpa_if.slave    cpa
);
    localparam int PROD_W = 64;
    localparam int ADD_W  = PROD_W - LSB_W;
    localparam int NSEG   = (ADD_W + SEG_W - 1) / SEG_W;
    localparam int PAD_W  = NSEG * SEG_W;
    localparam int CNT_W  = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int SH_W   = (PAD_W > 1) ? $clog2(PAD_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    seg_cnt_q;
    logic                cin_q;
    logic [ADD_W-1:0]    sum_q;
    logic [ADD_W:0]      carry_q;
    logic [PROD_W-1:0]   product_q;
    logic [TAG_W-1:0]    out_tag_q;
    logic                in_ready_q;
    logic                out_valid_q;

    logic [SH_W-1:0]     sh;
    logic [PAD_W-1:0]    sum_pad;
    logic [PAD_W-1:0]    carry_pad;
    logic [PAD_W-1:0]    hi_pad;
    logic [PAD_W-1:0]    slice_mask;
    logic [PAD_W-1:0]    slice_wr;
    logic [SEG_W-1:0]    slice_a;
    logic [SEG_W-1:0]    slice_b;
    logic [SEG_W:0]      slice_sum;
    logic [ADD_W-1:0]    hi_d;
    logic                cout_d;

    // Operands are zero-padded to a whole number of slices so every slice is
    // SEG_W wide; bits above ADD_W (including carry_vec's top bit and the final
    // slice carry-out) fall outside the product and are dropped on write-back.
    always_comb begin
        sh         = SH_W'(seg_cnt_q) * SH_W'(SEG_W);
        sum_pad    = PAD_W'(sum_q);
        carry_pad  = PAD_W'(carry_q);
        hi_pad     = PAD_W'(product_q[PROD_W-1:LSB_W]);
        slice_a    = SEG_W'(sum_pad >> sh);
        slice_b    = SEG_W'(carry_pad >> sh);
        slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + (SEG_W+1)'(cin_q);
        cout_d     = slice_sum[SEG_W];
        slice_mask = PAD_W'({SEG_W{1'b1}}) << sh;
        slice_wr   = PAD_W'(slice_sum[SEG_W-1:0]) << sh;
        hi_d       = ADD_W'((hi_pad & ~slice_mask) | slice_wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            seg_cnt_q   <= '0;
            cin_q       <= 1'b0;
            sum_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            out_tag_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cpa.in_valid) begin
                        sum_q                    <= cpa.sum_vec;
                        carry_q                  <= cpa.carry_vec;
                        product_q[LSB_W-1:0]     <= cpa.lsb_bits;
                        out_tag_q                <= cpa.in_tag;
                        seg_cnt_q                <= '0;
                        cin_q                    <= 1'b0;
                        in_ready_q               <= 1'b0;
                        state_q                  <= S_ADD;
                    end
                end
                S_ADD: begin
                    product_q[PROD_W-1:LSB_W] <= hi_d;
                    cin_q                     <= cout_d;
                    seg_cnt_q                 <= seg_cnt_q + 1'b1;
                    if (seg_cnt_q == CNT_W'(NSEG - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (cpa.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cpa.in_ready  = in_ready_q;
    assign cpa.out_valid = out_valid_q;
    assign cpa.product   = product_q;
    assign cpa.out_tag   = out_tag_q;
endmodule

// File: tb/tb_wallace_final_cpa.sv
// Self-checking bench for wallace_final_cpa: directed vector table, hand-written
// backpressure/reset sequences, and random operands against an arithmetic model.
module tb_wallace_final_cpa;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    wallace_final_cpa_if #(.LSB_W(6), .TAG_W(4)) bus ();

    wallace_final_cpa #(.LSB_W(6), .SEG_W(16), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .cpa (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [57:0] sum;
        logic [58:0] carry;
        logic [5:0]  lsb;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[4];

    // Product as plain 64-bit arithmetic: (sum + carry) shifted up by 6, OR low bits.
    function automatic logic [63:0] model(input logic [57:0] s, input logic [58:0] c,
                                          input logic [5:0] l);
        logic [63:0] t;
        t = 64'(s) + 64'(c);
        return (t << 6) | 64'(l);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One complete transaction. hold = cycles of out_ready=0 in DONE; poke drives
    // a junk in_valid during those cycles that must not be taken.
    task automatic do_op(input string nm, input logic [57:0] s, input logic [58:0] c,
                         input logic [5:0] l, input logic [3:0] tg, input logic [63:0] exp,
                         input int hold, input bit poke);
        int n;
        logic seen;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " in_ready before accept"}, 64'(bus.in_ready), 64'd1);
        bus.sum_vec   = s;
        bus.carry_vec = c;
        bus.lsb_bits  = l;
        bus.in_tag    = tg;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        check({nm, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, 64'(n), 64'd5);
        check({nm, " product"}, bus.product, exp);
        check({nm, " out_tag"}, 64'(bus.out_tag), 64'(tg));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                bus.in_valid  = 1'b1;
                bus.sum_vec   = 58'h155_5555_5555_5555;
                bus.carry_vec = 59'h1;
                bus.lsb_bits  = 6'h15;
                bus.in_tag    = ~tg;
            end
            @(negedge clk);
            check({nm, " hold product"}, bus.product, exp);
            check({nm, " hold tag"}, 64'(bus.out_tag), 64'(tg));
            check({nm, " hold valid"}, 64'(bus.out_valid), 64'd1);
            if (poke) check({nm, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
        check({nm, " in_ready back"}, 64'(bus.in_ready), 64'd1);
        if (poke) begin
            seen = 1'b0;
            repeat (7) begin
                @(negedge clk);
                seen |= bus.out_valid;
            end
            check({nm, " poke not latched"}, 64'(seen), 64'd0);
        end
    endtask

    initial begin
        logic        seen;
        logic [57:0] rs;
        logic [58:0] rc;
        logic [5:0]  rl;
        logic [3:0]  rt;
        logic [63:0] held;

        passed = 0;
        total  = 0;
        vecs[0] = '{sum: 58'h0, carry: 59'h0, lsb: 6'h2A, tag: 4'd3, exp: 64'h2A};
        vecs[1] = '{sum: 58'h000FFFF, carry: 59'h1, lsb: 6'h0, tag: 4'd1,
                    exp: 64'h0000_0000_0040_0000};
        vecs[2] = '{sum: 58'h3FF_FFFF_FFFF_FFFF, carry: 59'h1, lsb: 6'h3F, tag: 4'd9,
                    exp: 64'h3F};
        vecs[3] = '{sum: 58'h3FF_FFFF_F800_0000, carry: 59'h0, lsb: 6'h01, tag: 4'd12,
                    exp: 64'hFFFF_FFFE_0000_0001};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_vec   = '0;
        bus.carry_vec = '0;
        bus.lsb_bits  = '0;
        bus.in_tag    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset product", bus.product, 64'd0);
        check("reset out_tag", 64'(bus.out_tag), 64'd0);

        // out_ready while idle must be ignored
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        check("idle out_ready valid", 64'(bus.out_valid), 64'd0);
        check("idle out_ready in_ready", 64'(bus.in_ready), 64'd1);
        check("idle out_ready product", bus.product, 64'd0);

        for (int i = 0; i < 4; i++)
            do_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].carry, vecs[i].lsb,
                  vecs[i].tag, vecs[i].exp, 0, 1'b0);

        // Backpressure: 3 stalled cycles with a competing in_valid
        do_op("backpressure", 58'h123_4567_89AB_CDEF, 59'h0FE_DCBA_9876_5432, 6'h11, 4'd5,
              model(58'h123_4567_89AB_CDEF, 59'h0FE_DCBA_9876_5432, 6'h11), 3, 1'b1);

        // Reset two cycles after accept aborts the operation
        held = bus.product;
        bus.sum_vec   = 58'h0AB_CDEF_0123_4567;
        bus.carry_vec = 59'h2;
        bus.lsb_bits  = 6'h07;
        bus.in_tag    = 4'd6;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset in_ready", 64'(bus.in_ready), 64'd1);
        check("midreset product", bus.product, 64'd0);
        check("midreset out_tag", 64'(bus.out_tag), 64'd0);
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("midreset no out_valid", 64'(seen), 64'd0);
        do_op("after reset tag7", 58'h3FF_0000_FFFF_0000, 59'h000_FFFF_0001_0000, 6'h2B, 4'd7,
              model(58'h3FF_0000_FFFF_0000, 59'h000_FFFF_0001_0000, 6'h2B), 0, 1'b0);

        // Reset together with in_valid: nothing taken
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_tag    = 4'd2;
        bus.sum_vec   = 58'h1;
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check("rst+in_valid no out_valid", 64'(seen), 64'd0);
        check("rst+in_valid product", bus.product, 64'd0);
        if (held == 64'hx) $display("note: unreachable");

        // Randomized operands against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rs = 58'({$urandom(), $urandom()});
            rc = 59'({$urandom(), $urandom()});
            rl = 6'($urandom());
            rt = 4'($urandom());
            if (i % 8 == 0) begin
                rs = '1;
                rc = 59'($urandom_range(1, 3));
            end
            do_op($sformatf("rand%0d", i), rs, rc, rl, rt, model(rs, rc, rl),
                  int'($urandom_range(0, 3)), 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
